// File: rtl/imem_loader.sv
// -----------------------------------------------------------------------------
// imem_loader
//
// Boot-time instruction memory loader. Takes a byte stream (most significant
// byte of each word first), packs four bytes into a 32-bit word, and writes
// each word into instruction memory at consecutive word-aligned byte addresses
// starting at BASE. The CPU is held off from fetching until a load completes.
//
// Parameters
//   DEPTH      instruction memory capacity in 32-bit words
//   BASE       byte address of the first loaded word
//
// Ports
//   clk        single clock, rising edge
//   rst        asynchronous active-high reset
//   start      one-cycle request to begin a load (honoured in IDLE/DONE only)
//   load_len   number of words to load, sampled with an accepted start
//   byte_valid byte_data holds a valid byte
//   byte_data  program byte stream
//   byte_ready loader accepts a byte this cycle
//   mem_we     instruction memory write strobe
//   mem_addr   word-aligned byte address of the write
//   mem_wdata  assembled instruction word
//   busy       load in progress
//   done       last load completed
//   err        last start was rejected (bad length)
//   cpu_hold   CPU held from fetching
// -----------------------------------------------------------------------------
module imem_loader #(
  parameter int unsigned DEPTH = 256,
  parameter logic [31:0] BASE  = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        start,
  input  logic [15:0] load_len,
  input  logic        byte_valid,
  input  logic [7:0]  byte_data,
  output logic        byte_ready,
  output logic        mem_we,
  output logic [31:0] mem_addr,
  output logic [31:0] mem_wdata,
  output logic        busy,
  output logic        done,
  output logic        err,
  output logic        cpu_hold
);

  typedef enum logic [1:0] {
    S_IDLE,
    S_COLLECT,
    S_WRITE,
    S_DONE
  } state_t;

  state_t      state;
  state_t      state_next;

  logic [15:0] len_q;
  logic [15:0] index_q;
  logic [15:0] index_inc;
  logic [1:0]  byte_cnt;
  logic [23:0] partial_q;

  logic        start_acc;
  logic        len_bad;
  logic        xfer;
  logic        last_byte;

  // Handshake and start qualification. A start is only honoured when no load
  // is underway; the length check is done against the full 16-bit request so
  // a zero or oversize length can never begin collecting bytes.
  always_comb begin
    start_acc  = start && ((state == S_IDLE) || (state == S_DONE));
    len_bad    = (load_len == 16'd0) || ({16'd0, load_len} > DEPTH);
    xfer       = byte_valid && (state == S_COLLECT);
    last_byte  = xfer && (byte_cnt == 2'd3);
    index_inc  = index_q + 16'd1;
  end

  // State register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= S_IDLE;
    end else begin
      state <= state_next;
    end
  end

  // Next-state logic. A rejected start parks in IDLE so cpu_hold stays high.
  // WRITE always lasts exactly one cycle, then either finishes or returns to
  // collecting the next word.
  always_comb begin
    state_next = state;
    case (state)
      S_IDLE, S_DONE: begin
        if (start_acc) begin
          state_next = len_bad ? S_IDLE : S_COLLECT;
        end
      end
      S_COLLECT: begin
        if (last_byte) begin
          state_next = S_WRITE;
        end
      end
      S_WRITE: begin
        state_next = (index_inc == len_q) ? S_DONE : S_COLLECT;
      end
      default: begin
        state_next = S_IDLE;
      end
    endcase
  end

  // Datapath. The write address and data are captured on the edge of the
  // fourth byte so they are already stable for the whole WRITE cycle, and then
  // simply hold until the next word completes. Reset discards any partial word
  // and the latched length.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      len_q     <= 16'd0;
      index_q   <= 16'd0;
      byte_cnt  <= 2'd0;
      partial_q <= 24'd0;
      mem_addr  <= BASE;
      mem_wdata <= 32'd0;
      err       <= 1'b0;
    end else begin
      if (start_acc) begin
        err <= len_bad;
        if (!len_bad) begin
          len_q    <= load_len;
          index_q  <= 16'd0;
          byte_cnt <= 2'd0;
        end
      end

      if (xfer) begin
        byte_cnt  <= byte_cnt + 2'd1;
        partial_q <= {partial_q[15:0], byte_data};
        if (last_byte) begin
          mem_wdata <= {partial_q, byte_data};
          mem_addr  <= BASE + {14'd0, index_q, 2'b00};
        end
      end

      if (state == S_WRITE) begin
        index_q  <= index_inc;
        byte_cnt <= 2'd0;
      end
    end
  end

  // Status outputs decode directly from the state register.
  always_comb begin
    byte_ready = (state == S_COLLECT);
    mem_we     = (state == S_WRITE);
    busy       = (state == S_COLLECT) || (state == S_WRITE);
    done       = (state == S_DONE);
    cpu_hold   = (state != S_DONE);
  end

endmodule

// File: tb/tb_imem_loader.sv
// -----------------------------------------------------------------------------
// tb_imem_loader
//
// Self-checking bench for imem_loader. Two instances share all inputs: one at
// BASE=0 and one at BASE=0x400, so address sequences for both bases are
// exercised by the same stream. A transaction-level model predicts every
// output each cycle; directed literal checks pin the model at key points.
// -----------------------------------------------------------------------------
module tb_imem_loader;

  localparam logic [31:0] BASE0 = 32'h0000_0000;
  localparam logic [31:0] BASE1 = 32'h0000_0400;

  logic        clk;
  logic        rst;
  logic        start;
  logic [15:0] load_len;
  logic        byte_valid;
  logic [7:0]  byte_data;

  logic        r0_byte_ready, r0_mem_we, r0_busy, r0_done, r0_err, r0_cpu_hold;
  logic [31:0] r0_mem_addr, r0_mem_wdata;
  logic        r1_byte_ready, r1_mem_we, r1_busy, r1_done, r1_err, r1_cpu_hold;
  logic [31:0] r1_mem_addr, r1_mem_wdata;

  int checks = 0;
  int errors = 0;

  logic [63:0] log0[$];
  logic [63:0] log1[$];

  imem_loader #(.DEPTH(256), .BASE(BASE0)) dut0 (
    .clk(clk), .rst(rst), .start(start), .load_len(load_len),
    .byte_valid(byte_valid), .byte_data(byte_data),
    .byte_ready(r0_byte_ready), .mem_we(r0_mem_we), .mem_addr(r0_mem_addr),
    .mem_wdata(r0_mem_wdata), .busy(r0_busy), .done(r0_done), .err(r0_err),
    .cpu_hold(r0_cpu_hold)
  );

  imem_loader #(.DEPTH(256), .BASE(BASE1)) dut1 (
    .clk(clk), .rst(rst), .start(start), .load_len(load_len),
    .byte_valid(byte_valid), .byte_data(byte_data),
    .byte_ready(r1_byte_ready), .mem_we(r1_mem_we), .mem_addr(r1_mem_addr),
    .mem_wdata(r1_mem_wdata), .busy(r1_busy), .done(r1_done), .err(r1_err),
    .cpu_hold(r1_cpu_hold)
  );

  // 10-unit clock.
  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic checkOutput(input string name, input logic [63:0] actual,
                             input logic [63:0] expected);
    checks++;
    if (actual !== expected) begin
      errors++;
      $display("[TB] FAIL %s actual=%h expected=%h", name, actual, expected);
    end
  endtask

  // Transaction-level model: a load is either active (collecting or in its
  // write cycle), finished, or not running. Words are assembled from a queue
  // of received bytes, and the write offset is 4 * words already written.
  logic        m_active    = 1'b0;
  logic        m_write_now = 1'b0;
  logic        m_done      = 1'b0;
  logic        m_err       = 1'b0;
  int          m_len       = 0;
  int          m_words     = 0;
  logic [31:0] m_off       = 32'd0;
  logic [31:0] m_wdata     = 32'd0;
  logic [7:0]  m_bytes[$];

  always @(posedge clk or posedge rst) begin : model
    int words_n;
    if (rst) begin
      m_active    <= 1'b0;
      m_write_now <= 1'b0;
      m_done      <= 1'b0;
      m_err       <= 1'b0;
      m_len       <= 0;
      m_words     <= 0;
      m_off       <= 32'd0;
      m_wdata     <= 32'd0;
      m_bytes.delete();
    end else if (m_write_now) begin
      words_n = m_words + 1;
      m_write_now <= 1'b0;
      m_words     <= words_n;
      if (words_n == m_len) begin
        m_active <= 1'b0;
        m_done   <= 1'b1;
      end
    end else if (m_active) begin
      if (byte_valid) begin
        if (m_bytes.size() == 3) begin
          m_wdata <= (32'(m_bytes[0]) << 24) | (32'(m_bytes[1]) << 16) |
                     (32'(m_bytes[2]) << 8) | 32'(byte_data);
          m_off   <= 32'(m_words * 4);
          m_bytes.delete();
          m_write_now <= 1'b1;
        end else begin
          m_bytes.push_back(byte_data);
        end
      end
    end else if (start) begin
      m_done <= 1'b0;
      if (load_len == 16'd0 || int'(load_len) > 256) begin
        m_err <= 1'b1;
      end else begin
        m_err    <= 1'b0;
        m_active <= 1'b1;
        m_len    <= int'(load_len);
        m_words  <= 0;
        m_bytes.delete();
      end
    end
  end

  // Per-cycle comparison against the model, plus a log of observed writes.
  always @(negedge clk) begin
    checkOutput("d0.byte_ready", 64'(r0_byte_ready), 64'(m_active && !m_write_now));
    checkOutput("d0.mem_we",     64'(r0_mem_we),     64'(m_write_now));
    checkOutput("d0.busy",       64'(r0_busy),       64'(m_active));
    checkOutput("d0.done",       64'(r0_done),       64'(m_done));
    checkOutput("d0.err",        64'(r0_err),        64'(m_err));
    checkOutput("d0.cpu_hold",   64'(r0_cpu_hold),   64'(!m_done));
    checkOutput("d0.mem_addr",   64'(r0_mem_addr),   64'(BASE0 + m_off));
    checkOutput("d0.mem_wdata",  64'(r0_mem_wdata),  64'(m_wdata));
    checkOutput("d1.mem_we",     64'(r1_mem_we),     64'(m_write_now));
    checkOutput("d1.cpu_hold",   64'(r1_cpu_hold),   64'(!m_done));
    checkOutput("d1.mem_addr",   64'(r1_mem_addr),   64'(BASE1 + m_off));
    checkOutput("d1.mem_wdata",  64'(r1_mem_wdata),  64'(m_wdata));
    if (r0_mem_we) log0.push_back({r0_mem_addr, r0_mem_wdata});
    if (r1_mem_we) log1.push_back({r1_mem_addr, r1_mem_wdata});
  end

  // Drive one cycle of inputs; returns 2 units after the sampling edge.
  task automatic applyStimulus(input logic s, input logic [15:0] len,
                               input logic v, input logic [7:0] d);
    start      = s;
    load_len   = len;
    byte_valid = v;
    byte_data  = d;
    @(posedge clk);
    #2;
  endtask

  task automatic idleCycles(input int n);
    for (int i = 0; i < n; i++) applyStimulus(1'b0, 16'd0, 1'b0, 8'($urandom));
  endtask

  // Offer a byte until it is accepted, bounded so the bench cannot hang.
  task automatic sendByte(input logic [7:0] b);
    logic rdy;
    int   n;
    rdy        = 1'b0;
    n          = 0;
    start      = 1'b0;
    load_len   = 16'd0;
    byte_valid = 1'b1;
    byte_data  = b;
    while (!rdy && n < 20) begin
      rdy = r0_byte_ready;
      @(posedge clk);
      #2;
      n++;
    end
    if (!rdy) begin
      checks++;
      errors++;
      $display("[TB] FAIL sendByte_timeout actual=no_transfer expected=transfer");
    end
    byte_valid = 1'b0;
    byte_data  = 8'($urandom);
  endtask

  task automatic sendWord(input logic [31:0] w);
    sendByte(w[31:24]);
    sendByte(w[23:16]);
    sendByte(w[15:8]);
    sendByte(w[7:0]);
  endtask

  initial begin
    rst        = 1'b1;
    start      = 1'b0;
    load_len   = 16'd0;
    byte_valid = 1'b0;
    byte_data  = 8'd0;

    // Reset values.
    idleCycles(2);
    checkOutput("rst.cpu_hold",  64'(r0_cpu_hold),  64'd1);
    checkOutput("rst.busy",      64'(r0_busy),      64'd0);
    checkOutput("rst.d0_addr",   64'(r0_mem_addr),  64'h0);
    checkOutput("rst.d1_addr",   64'(r1_mem_addr),  64'h400);
    checkOutput("rst.wdata",     64'(r0_mem_wdata), 64'h0);
    rst = 1'b0;
    idleCycles(2);

    // Two-word load.
    $display("[TB] two-word load");
    log0.delete(); log1.delete();
    applyStimulus(1'b1, 16'd2, 1'b0, 8'h00);
    sendWord(32'h8C01_0004);
    sendWord(32'hAC02_0008);
    idleCycles(2);
    checkOutput("two.count",   64'(log0.size()), 64'd2);
    checkOutput("two.w0",      log0[0], {32'h0, 32'h8C01_0004});
    checkOutput("two.w1",      log0[1], {32'h4, 32'hAC02_0008});
    checkOutput("two.d1_w0",   log1[0], {32'h400, 32'h8C01_0004});
    checkOutput("two.done",    64'(r0_done),     64'd1);
    checkOutput("two.cpu_hold", 64'(r0_cpu_hold), 64'd0);

    // Restart from DONE with a gappy byte stream.
    $display("[TB] restart with toggled byte_valid");
    log0.delete(); log1.delete();
    applyStimulus(1'b1, 16'd1, 1'b0, 8'h00);
    checkOutput("restart.cpu_hold", 64'(r0_cpu_hold), 64'd1);
    applyStimulus(1'b0, 16'd0, 1'b0, 8'hFF);
    sendByte(8'h11);
    applyStimulus(1'b0, 16'd0, 1'b0, 8'hEE);
    sendByte(8'h22);
    applyStimulus(1'b0, 16'd0, 1'b0, 8'hDD);
    sendByte(8'h33);
    applyStimulus(1'b0, 16'd0, 1'b0, 8'hCC);
    sendByte(8'h44);
    checkOutput("gap.we_latency", 64'(r0_mem_we), 64'd1);
    idleCycles(1);
    checkOutput("gap.we_once",  64'(r0_mem_we),   64'd0);
    checkOutput("gap.count",    64'(log0.size()), 64'd1);
    checkOutput("gap.w0",       log0[0], {32'h0, 32'h1122_3344});
    checkOutput("gap.d1_w0",    log1[0], {32'h400, 32'h1122_3344});

    // Rejected lengths.
    $display("[TB] rejected lengths");
    log0.delete(); log1.delete();
    applyStimulus(1'b1, 16'd0, 1'b0, 8'h00);
    checkOutput("len0.err",      64'(r0_err),      64'd1);
    checkOutput("len0.done",     64'(r0_done),     64'd0);
    checkOutput("len0.cpu_hold", 64'(r0_cpu_hold), 64'd1);
    applyStimulus(1'b1, 16'd257, 1'b1, 8'h5A);
    checkOutput("len257.err",    64'(r0_err),      64'd1);
    checkOutput("len257.busy",   64'(r0_busy),     64'd0);
    for (int i = 0; i < 3; i++) applyStimulus(1'b0, 16'd0, 1'b1, 8'(i));
    checkOutput("reject.nowrite", 64'(log0.size()), 64'd0);

    // Stray start in COLLECT and a long stall mid-word.
    $display("[TB] stray start and stall");
    applyStimulus(1'b1, 16'd2, 1'b0, 8'h00);
    checkOutput("stray.err_clr", 64'(r0_err), 64'd0);
    sendByte(8'hDE);
    sendByte(8'hAD);
    applyStimulus(1'b1, 16'd5, 1'b0, 8'h00);
    idleCycles(10);
    checkOutput("stall.busy", 64'(r0_busy), 64'd1);
    sendByte(8'hBE);
    sendByte(8'hEF);
    sendWord(32'h0123_4567);
    idleCycles(2);
    checkOutput("stray.count", 64'(log0.size()), 64'd2);
    checkOutput("stray.w0",    log0[0], {32'h0, 32'hDEAD_BEEF});
    checkOutput("stray.w1",    log0[1], {32'h4, 32'h0123_4567});
    checkOutput("stray.done",  64'(r0_done), 64'd1);

    // Maximum length accepted, then reset mid-word.
    $display("[TB] reset mid-load");
    log0.delete(); log1.delete();
    applyStimulus(1'b1, 16'd256, 1'b0, 8'h00);
    checkOutput("len256.busy", 64'(r0_busy), 64'd1);
    sendWord(32'hA1B2_C3D4);
    sendByte(8'h99);
    sendByte(8'h88);
    #1 rst = 1'b1;
    #1;
    checkOutput("midrst.byte_ready", 64'(r0_byte_ready), 64'd0);
    checkOutput("midrst.addr",       64'(r1_mem_addr),   64'h400);
    @(posedge clk);
    #2;
    checkOutput("midrst.wdata",      64'(r0_mem_wdata),  64'h0);
    checkOutput("midrst.cpu_hold",   64'(r0_cpu_hold),   64'd1);
    rst = 1'b0;
    for (int i = 0; i < 4; i++) applyStimulus(1'b0, 16'd0, 1'b1, 8'h77);
    checkOutput("midrst.count", 64'(log0.size()), 64'd1);
    checkOutput("midrst.idle",  64'(r0_busy),     64'd0);
    applyStimulus(1'b1, 16'd1, 1'b0, 8'h00);
    sendWord(32'hCAFE_F00D);
    idleCycles(2);
    checkOutput("postrst.count", 64'(log0.size()), 64'd2);
    checkOutput("postrst.w0",    log0[1], {32'h0, 32'hCAFE_F00D});
    checkOutput("postrst.d1_w0", log1[1], {32'h400, 32'hCAFE_F00D});

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/imem_loader.md
IMEM_LOADER -- requirements
Module: imem_loader

Interface
- REQ-001 SHALL have parameter DEPTH, default 256: instruction-memory capacity in 32-bit words.
- REQ-002 SHALL have parameter BASE, default 32'h0000_0000: byte address of the first loaded word.
- REQ-003 SHALL have port clk, input, 1: the single clock; all state updates on its rising edge.
- REQ-004 SHALL have port rst, input, 1: asynchronous, active-high reset.
- REQ-005 SHALL have port start, input, 1: one-cycle request to begin a load.
- REQ-006 SHALL have port load_len, input, 16: number of words to load; sampled only with an accepted start.
- REQ-007 SHALL have port byte_valid, input, 1: byte_data holds a valid byte.
- REQ-008 SHALL have port byte_data, input, 8: program byte stream, most significant byte of each word first.
- REQ-009 SHALL have port byte_ready, output, 1: loader accepts a byte this cycle.
- REQ-010 SHALL have port mem_we, output, 1: instruction-memory write strobe.
- REQ-011 SHALL have port mem_addr, output, 32: byte address, always word-aligned.
- REQ-012 SHALL have port mem_wdata, output, 32: assembled instruction word.
- REQ-013 SHALL have port busy, output, 1: a load is in progress.
- REQ-014 SHALL have port done, output, 1: the last load completed.
- REQ-015 SHALL have port err, output, 1: the last start was rejected.
- REQ-016 SHALL have port cpu_hold, output, 1: CPU held from fetching.

Function
- REQ-017 SHALL implement states IDLE, COLLECT, WRITE and DONE; all outputs SHALL be registered or decoded from state only.
- REQ-018 SHALL accept start only in IDLE or DONE; start in COLLECT or WRITE SHALL be ignored.
- REQ-019 On an accepted start with load_len==0 or load_len>DEPTH: SHALL set err=1 and done=0, and go to IDLE with cpu_hold=1.
- REQ-020 On an accepted valid start: SHALL latch load_len, clear the word index and byte count, set err=0 and done=0, and go to COLLECT.
- REQ-021 SHALL drive byte_ready=1 only in COLLECT; a byte transfers on a rising edge where byte_valid and byte_ready are both 1.
- REQ-022 SHALL place transferred byte n (n=0..3) of a word into mem_wdata bits [31-8n:24-8n]; byte_data SHALL be ignored when no transfer occurs.
- REQ-023 On the edge transferring the 4th byte: SHALL go to WRITE.
- REQ-024 In WRITE: SHALL drive mem_we=1 for exactly one cycle, with mem_addr=BASE+4*index and mem_wdata equal to the assembled word.
- REQ-025 Write latency: mem_we SHALL be high in the cycle immediately after the 4th byte's transfer edge.
- REQ-026 Leaving WRITE: index SHALL increment; if index then equals the latched length, SHALL go to DONE, else back to COLLECT with the byte count at 0.
- REQ-027 mem_we SHALL be 0 in every state except WRITE; mem_addr and mem_wdata SHALL hold their values outside WRITE.
- REQ-028 SHALL set busy=1 exactly in COLLECT and WRITE.
- REQ-029 SHALL set done=1 exactly in DONE.
- REQ-030 SHALL set cpu_hold=1 in every state except DONE.
- REQ-031 A start accepted in DONE SHALL reassert cpu_hold in the following cycle.
- REQ-032 Index arithmetic SHALL be 16-bit; mem_addr SHALL wrap modulo 2^32.
- REQ-033 An idle byte stream (byte_valid=0) SHALL stall indefinitely with no timeout and no state change.

Reset
- REQ-034 While rst=1: state SHALL be IDLE; byte_ready=0, mem_we=0, mem_addr=BASE, mem_wdata=0, busy=0, done=0, err=0, cpu_hold=1.
- REQ-035 rst asserted mid-load SHALL discard the partial word and latched length immediately; no write strobe SHALL follow.
- REQ-036 After rst deasserts, the block SHALL require a new start.

Verification
- REQ-037 Reset then start with load_len=2, bytes 8C,01,00,04,AC,02,00,08 -> writes 8C010004@0x0 and AC020008@0x4, each mem_we one cycle; done=1 and cpu_hold=0 after the 2nd write.
- REQ-038 byte_valid toggled every other cycle during a 1-word load -> exactly 4 transfers, then mem_we one cycle after the 4th transfer edge.
- REQ-039 start with load_len=0, then start with load_len=257 (DEPTH=256) -> err=1 each time, no mem_we, cpu_hold=1, busy=0.
- REQ-040 Extra start pulsed in COLLECT -> ignored: index and address sequence continue unchanged.
- REQ-041 rst pulsed after 2 bytes of word 1 -> all outputs at reset values; no mem_we; a following 1-word load writes to BASE.
- REQ-042 Second start in DONE with BASE=0x400 -> cpu_hold rises the next cycle; addresses restart at 0x400.
